// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StAlarm = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } mmss_t;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/timer_mode_controller_if.sv
// Front-panel, digit-setting and display-side signals of the timer sequencer.
interface timer_mode_controller_if;

  logic       btn_mode;
  logic       btn_start;
  logic       btn_clear;
  logic [3:0] set_min_tens;
  logic [3:0] set_min_units;
  logic [3:0] set_sec_tens;
  logic [3:0] set_sec_units;
  logic       setting_enable;
  logic [3:0] cnt_min_tens;
  logic [3:0] cnt_min_units;
  logic [3:0] cnt_sec_tens;
  logic [3:0] cnt_sec_units;
  logic       alarm;
  logic [2:0] state;

  modport master (
    output btn_mode, btn_start, btn_clear,
    output set_min_tens, set_min_units, set_sec_tens, set_sec_units,
    input  setting_enable, cnt_min_tens, cnt_min_units, cnt_sec_tens, cnt_sec_units,
    input  alarm, state
  );

  modport slave (
    input  btn_mode, btn_start, btn_clear,
    input  set_min_tens, set_min_units, set_sec_tens, set_sec_units,
    output setting_enable, cnt_min_tens, cnt_min_units, cnt_sec_tens, cnt_sec_units,
    output alarm, state
  );

endinterface

// File: rtl/bcd_mmss_decrement.sv
// Combinational one-second decrement of an MM:SS BCD value with borrow chain.
module bcd_mmss_decrement
  import timer_pkg::*;
(
  input  logic [3:0] min_tens_i,
  input  logic [3:0] min_units_i,
  input  logic [3:0] sec_tens_i,
  input  logic [3:0] sec_units_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_units_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_units_o,
  output logic       is_zero_after_o
);

  logic borrow_su, borrow_st, borrow_mu;

  always_comb begin
    borrow_su   = (sec_units_i == 4'd0);
    sec_units_o = borrow_su ? UNITS_MAX : sec_units_i - 4'd1;

    borrow_st   = borrow_su && (sec_tens_i == 4'd0);
    sec_tens_o  = !borrow_su ? sec_tens_i :
                  (sec_tens_i == 4'd0) ? TENS_MAX : sec_tens_i - 4'd1;

    borrow_mu   = borrow_st && (min_units_i == 4'd0);
    min_units_o = !borrow_st ? min_units_i :
                  (min_units_i == 4'd0) ? UNITS_MAX : min_units_i - 4'd1;

    min_tens_o  = borrow_mu ? min_tens_i - 4'd1 : min_tens_i;

    is_zero_after_o = (min_tens_o == 4'd0) && (min_units_o == 4'd0) &&
                      (sec_tens_o == 4'd0) && (sec_units_o == 4'd0);
  end

endmodule

// File: rtl/timer_mode_controller.sv
// Countdown timer sequencer: owns the MM:SS digits, loads, counts down once per
// second from the 4 Hz clock and holds the alarm state.
module timer_mode_controller
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 4,
  parameter int unsigned ALARM_SECS    = 10
) (
  input logic                    clk4,
  input logic                    reset,
  timer_mode_controller_if.slave tmr_io
);

  localparam int unsigned AlarmCycles = ALARM_SECS * TICKS_PER_SEC;
  localparam int unsigned PreW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned AlmW = (AlarmCycles > 2) ? $clog2(AlarmCycles) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_SEC - 1);
  localparam logic [AlmW-1:0] AlmMax = AlmW'(AlarmCycles - 1);

  state_e          state_q, state_d;
  mmss_t           cnt_q, cnt_d, load_val, dec_val;
  logic            dec_zero, cnt_zero, load_zero;
  logic [2:0]      btn, btn_q, press;
  logic            clr_p, start_p, mode_p;
  logic [PreW-1:0] pre_q, pre_d;
  logic [AlmW-1:0] alm_q, alm_d;
  logic            alarm_q;

  bcd_mmss_decrement u_dec (
    .min_tens_i      (cnt_q.min_tens),
    .min_units_i     (cnt_q.min_units),
    .sec_tens_i      (cnt_q.sec_tens),
    .sec_units_i     (cnt_q.sec_units),
    .min_tens_o      (dec_val.min_tens),
    .min_units_o     (dec_val.min_units),
    .sec_tens_o      (dec_val.sec_tens),
    .sec_units_o     (dec_val.sec_units),
    .is_zero_after_o (dec_zero)
  );

  // Priority clear > start > mode; only the winning press acts.
  assign btn     = {tmr_io.btn_clear, tmr_io.btn_start, tmr_io.btn_mode};
  assign press   = btn & ~btn_q;
  assign clr_p   = press[2];
  assign start_p = press[1] & ~press[2];
  assign mode_p  = press[0] & ~press[1] & ~press[2];

  assign load_val.min_tens  = clamp_digit(tmr_io.set_min_tens, TENS_MAX);
  assign load_val.min_units = clamp_digit(tmr_io.set_min_units, UNITS_MAX);
  assign load_val.sec_tens  = clamp_digit(tmr_io.set_sec_tens, TENS_MAX);
  assign load_val.sec_units = clamp_digit(tmr_io.set_sec_units, UNITS_MAX);
  assign load_zero = (load_val == '0);
  assign cnt_zero  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    alm_d   = '0;
    case (state_q)
      StIdle: begin
        if (clr_p) begin
          cnt_d = '0;
        end else if (start_p) begin
          if (!cnt_zero) begin
            state_d = StRun;
            pre_d   = '0;
          end
        end else if (mode_p) begin
          state_d = StSet;
        end
      end
      StSet: begin
        if (clr_p) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (start_p) begin
          cnt_d   = load_val;
          pre_d   = '0;
          state_d = load_zero ? StIdle : StRun;
        end else if (mode_p) begin
          cnt_d   = load_val;
          state_d = StIdle;
        end
      end
      StRun: begin
        if (clr_p) begin
          cnt_d   = '0;
          pre_d   = '0;
          state_d = StIdle;
        end else if (start_p) begin
          state_d = StPause;
        end else if (pre_q == PreMax) begin
          pre_d = '0;
          cnt_d = dec_val;
          if (dec_zero) state_d = StAlarm;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      StPause: begin
        if (clr_p) begin
          cnt_d   = '0;
          pre_d   = '0;
          state_d = StIdle;
        end else if (start_p) begin
          state_d = StRun;
        end
      end
      StAlarm: begin
        if ((press != 3'b000) || (alm_q == AlmMax)) begin
          pre_d   = '0;
          state_d = StIdle;
        end else begin
          alm_d = alm_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pre_q   <= '0;
      alm_q   <= '0;
      btn_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      alm_q   <= alm_d;
      btn_q   <= btn;
      alarm_q <= (state_d == StAlarm);
    end
  end

  assign tmr_io.setting_enable = (state_q == StSet);
  assign tmr_io.alarm          = alarm_q;
  assign tmr_io.state          = state_q;
  assign tmr_io.cnt_min_tens   = cnt_q.min_tens;
  assign tmr_io.cnt_min_units  = cnt_q.min_units;
  assign tmr_io.cnt_sec_tens   = cnt_q.sec_tens;
  assign tmr_io.cnt_sec_units  = cnt_q.sec_units;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Directed and random stimulus for timer_mode_controller against a seconds-based model.
module tb_timer_mode_controller;

  localparam int Tps = 4;
  localparam int As  = 10;

  logic clk4 = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: time held as a plain number of seconds.
  int m_state, m_secs, m_pre, m_alm;
  logic [2:0] m_prev;

  timer_mode_controller_if intf ();

  timer_mode_controller #(
    .TICKS_PER_SEC (Tps),
    .ALARM_SECS    (As)
  ) dut (
    .clk4   (clk4),
    .reset  (reset),
    .tmr_io (intf.slave)
  );

  always #5 clk4 = ~clk4;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampd(input logic [3:0] d, input int lim);
    return (int'(d) > lim) ? lim : int'(d);
  endfunction

  function automatic logic [15:0] digits(input int s);
    logic [15:0] v;
    v = {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    return v;
  endfunction

  function automatic logic [31:0] model_vec();
    return {11'd0, 3'(m_state), (m_state == 4), (m_state == 1), digits(m_secs)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {11'd0, intf.state, intf.alarm, intf.setting_enable, intf.cnt_min_tens,
            intf.cnt_min_units, intf.cnt_sec_tens, intf.cnt_sec_units};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {intf.cnt_min_tens, intf.cnt_min_units, intf.cnt_sec_tens, intf.cnt_sec_units};
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_pre = 0; m_alm = 0; m_prev = '0;
  endtask

  // Advances the model by one clock edge from the inputs currently applied.
  task automatic model_step();
    logic [2:0] b, p;
    logic clr, st, md;
    int load;
    b = {intf.btn_clear, intf.btn_start, intf.btn_mode};
    p = b & ~m_prev;
    m_prev = b;
    clr = p[2];
    st  = p[1] & ~p[2];
    md  = p[0] & ~p[1] & ~p[2];
    load = (clampd(intf.set_min_tens, 5) * 10 + clampd(intf.set_min_units, 9)) * 60 +
           clampd(intf.set_sec_tens, 5) * 10 + clampd(intf.set_sec_units, 9);
    case (m_state)
      0: if (clr) m_secs = 0;
         else if (st) begin
           if (m_secs != 0) begin m_state = 2; m_pre = 0; end
         end else if (md) m_state = 1;
      1: if (clr) begin m_secs = 0; m_state = 0; end
         else if (st) begin m_secs = load; m_pre = 0; m_state = (load != 0) ? 2 : 0; end
         else if (md) begin m_secs = load; m_state = 0; end
      2: if (clr) begin m_secs = 0; m_pre = 0; m_state = 0; end
         else if (st) m_state = 3;
         else begin
           m_pre++;
           if (m_pre == Tps) begin
             m_pre = 0;
             m_secs--;
             if (m_secs == 0) m_state = 4;
           end
         end
      3: if (clr) begin m_secs = 0; m_pre = 0; m_state = 0; end
         else if (st) m_state = 2;
      default: begin
        if (p != 3'b000 || m_alm == Tps * As - 1) begin
          m_state = 0; m_alm = 0; m_pre = 0;
        end else m_alm++;
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk4);
    #1;
    check_eq("cyc", dut_vec(), model_vec());
  endtask

  task automatic set_val(input logic [3:0] mt, mu, st, su);
    intf.set_min_tens = mt; intf.set_min_units = mu;
    intf.set_sec_tens = st; intf.set_sec_units = su;
  endtask

  // idx 0 = mode, 1 = start, 2 = clear; several bits press together.
  task automatic press(input logic [2:0] b);
    {intf.btn_clear, intf.btn_start, intf.btn_mode} = b;
    cycle();
    {intf.btn_clear, intf.btn_start, intf.btn_mode} = 3'b000;
    cycle();
  endtask

  task automatic press_now(input logic [2:0] b);
    {intf.btn_clear, intf.btn_start, intf.btn_mode} = b;
    cycle();
    {intf.btn_clear, intf.btn_start, intf.btn_mode} = 3'b000;
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    check_eq(tag, dut_vec(), 32'd0);
    model_reset();
    @(posedge clk4);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int hi, changes;
    logic [2:0] prev_state;
    reset = 1'b1;
    {intf.btn_clear, intf.btn_start, intf.btn_mode} = 3'b000;
    set_val(0, 0, 0, 3);
    model_reset();
    #12;
    check_eq("rst", dut_vec(), 32'd0);
    reset = 1'b0;
    cycle();

    // 00:03 countdown into alarm
    press(3'b001);
    press(3'b001);
    check_eq("t1_load", 32'(dut_digits()), 32'h0003);
    press_now(3'b010);
    repeat (4) cycle();
    check_eq("t1_02", 32'(dut_digits()), 32'h0002);
    repeat (4) cycle();
    check_eq("t1_01", 32'(dut_digits()), 32'h0001);
    repeat (4) cycle();
    check_eq("t1_00", 32'(dut_digits()), 32'h0000);
    check_eq("t1_state", 32'(intf.state), 32'd4);
    check_eq("t1_alarm", 32'(intf.alarm), 32'd1);
    hi = 0;
    while (intf.alarm && hi < 100) begin
      hi++;
      cycle();
    end
    check_eq("t1_alarm_len", hi, 40);

    // borrow chains
    press(3'b001);
    set_val(1, 0, 0, 0);
    press_now(3'b010);
    repeat (4) cycle();
    check_eq("t2_0959", 32'(dut_digits()), 32'h0959);
    press(3'b100);
    press(3'b001);
    set_val(0, 1, 0, 0);
    press_now(3'b010);
    repeat (4) cycle();
    check_eq("t2_0059", 32'(dut_digits()), 32'h0059);
    press(3'b100);

    // pause with prescaler at 2
    press(3'b001);
    set_val(0, 0, 0, 5);
    press_now(3'b010);
    repeat (2) cycle();
    press_now(3'b010);
    check_eq("t3_pause", 32'(intf.state), 32'd3);
    repeat (20) cycle();
    check_eq("t3_frozen", 32'(dut_digits()), 32'h0005);
    press_now(3'b010);
    cycle();
    check_eq("t3_res1", 32'(dut_digits()), 32'h0005);
    cycle();
    check_eq("t3_res2", 32'(dut_digits()), 32'h0004);

    // coincident presses in RUN
    press_now(3'b111);
    check_eq("t4_idle", 32'(intf.state), 32'd0);
    check_eq("t4_zero", 32'(dut_digits()), 32'h0000);
    cycle();
    press(3'b001);
    set_val(0, 0, 0, 7);
    press(3'b001);
    changes = 0;
    intf.btn_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prev_state = intf.state;
      cycle();
      if (intf.state != prev_state) changes++;
    end
    intf.btn_start = 1'b0;
    check_eq("t4_changes", changes, 1);
    check_eq("t4_run", 32'(intf.state), 32'd2);
    press(3'b100);

    // clamping and zero load
    press(3'b001);
    check_eq("t5_set_en", 32'(intf.setting_enable), 32'd1);
    set_val(7, 12, 9, 15);
    press_now(3'b001);
    check_eq("t5_clamp", 32'(dut_digits()), 32'h5959);
    cycle();
    press(3'b001);
    set_val(0, 0, 0, 0);
    press_now(3'b010);
    check_eq("t5_zero_idle", 32'(intf.state), 32'd0);
    cycle();
    check_eq("t5_no_alarm", 32'(intf.alarm), 32'd0);

    // async reset in ALARM and mid-RUN
    press(3'b001);
    set_val(0, 0, 0, 1);
    press_now(3'b010);
    repeat (5) cycle();
    check_eq("t6_in_alarm", 32'(intf.state), 32'd4);
    async_reset("t6_rst_alarm");
    cycle();
    press(3'b001);
    set_val(0, 2, 3, 4);
    press_now(3'b010);
    repeat (6) cycle();
    async_reset("t6_rst_run");
    cycle();

    // random phase
    for (int i = 0; i < 3000; i++) begin
      intf.btn_clear = ($urandom_range(0, 59) == 0);
      intf.btn_start = ($urandom_range(0, 9) == 0);
      intf.btn_mode  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 7) == 0)
          set_val(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        else
          set_val(0, 0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
